// File: rtl/alu_div_sequencer.sv
// alu_div_sequencer: multi-cycle restoring divider controller for the MIPS
// datapath. It performs one shift-subtract step per cycle for WIDTH cycles,
// stalls the pipeline through `busy`, and presents registered quotient and
// remainder for the HI/LO write-back.
//
// Optional feature: define DIV_SIGNED_EN to add the `is_signed` port and
// signed division (magnitudes divided, sign fix-up applied on the last step).
//
// Ports:
//   clk, rst_n            clock, asynchronous active-low reset
//   start                 divide request, sampled in IDLE or DONE
//   flush                 abort; back to IDLE, results untouched
//   is_signed             signed divide select (DIV_SIGNED_EN only)
//   dividend, divisor     operands, captured on an accepted start
//   busy                  pipeline stall: accept cycle plus all RUN cycles
//   done                  one-cycle pulse, results valid from this cycle
//   quotient, remainder   registered results
//   div_by_zero           registered flag, set with done for divisor == 0
module alu_div_sequencer #(
  parameter int unsigned WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             flush,
`ifdef DIV_SIGNED_EN
  input  logic             is_signed,
`endif
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder,
  output logic             div_by_zero
);

  localparam int unsigned CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CNT_W-1:0] LAST_ITER = CNT_W'(WIDTH - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t           state, state_nxt;
  logic [WIDTH-1:0] dvd_q;       // shifts out dividend bits, shifts in quotient bits
  logic [WIDTH-1:0] rem_q;       // partial remainder
  logic [WIDTH-1:0] dsr_q;       // captured divisor magnitude
  logic [CNT_W-1:0] cnt_q;
  logic             neg_quo_q;
  logic             neg_rem_q;
  logic [WIDTH-1:0] quotient_q;
  logic [WIDTH-1:0] remainder_q;
  logic             dbz_q;
  logic             done_q;

  logic             accept;
  logic             dsr_zero;
  logic             a_neg, b_neg;
  logic [WIDTH-1:0] a_mag, b_mag;
  logic [WIDTH:0]   sh_rem;
  logic [WIDTH:0]   trial;
  logic             borrow;
  logic [WIDTH-1:0] rem_it, quo_it;
  logic [WIDTH-1:0] quo_fix, rem_fix;

  // Start is honoured only between divides and never alongside a flush.
  assign accept   = start & ~flush & ((state == IDLE) || (state == DONE));
  assign dsr_zero = (divisor == '0);

  // Operand conditioning at capture: magnitudes for a signed divide.
  always_comb begin
    a_neg = 1'b0;
    b_neg = 1'b0;
`ifdef DIV_SIGNED_EN
    a_neg = is_signed & dividend[WIDTH-1];
    b_neg = is_signed & divisor[WIDTH-1];
`endif
    a_mag = a_neg ? -dividend : dividend;
    b_mag = b_neg ? -divisor : divisor;
  end

  // One restoring step; the extra top bit holds both the shifted-out MSB and the borrow.
  always_comb begin
    sh_rem  = {rem_q, dvd_q[WIDTH-1]};
    trial   = sh_rem - {1'b0, dsr_q};
    borrow  = trial[WIDTH];
    rem_it  = borrow ? sh_rem[WIDTH-1:0] : trial[WIDTH-1:0];
    quo_it  = {dvd_q[WIDTH-2:0], ~borrow};
    quo_fix = neg_quo_q ? -quo_it : quo_it;
    rem_fix = neg_rem_q ? -rem_it : rem_it;
  end

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  // Next-state logic; flush overrides everything.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: begin
        if (accept) state_nxt = dsr_zero ? DONE : RUN;
      end
      RUN: begin
        if (cnt_q == LAST_ITER) state_nxt = DONE;
      end
      DONE: begin
        if (accept) state_nxt = dsr_zero ? DONE : RUN;
        else        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
    if (flush) state_nxt = IDLE;
  end

  // Output decode: stall during RUN and in the accepting cycle.
  always_comb begin
    busy        = (state == RUN) | accept;
    done        = done_q;
    quotient    = quotient_q;
    remainder   = remainder_q;
    div_by_zero = dbz_q;
  end

  // Datapath and result registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      dvd_q       <= '0;
      rem_q       <= '0;
      dsr_q       <= '0;
      cnt_q       <= '0;
      neg_quo_q   <= 1'b0;
      neg_rem_q   <= 1'b0;
      quotient_q  <= '0;
      remainder_q <= '0;
      dbz_q       <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      done_q <= (state_nxt == DONE);
      case (state)
        IDLE, DONE: begin
          if (accept) begin
            if (dsr_zero) begin
              quotient_q  <= '1;
              remainder_q <= dividend;
              dbz_q       <= 1'b1;
            end else begin
              dvd_q     <= a_mag;
              dsr_q     <= b_mag;
              rem_q     <= '0;
              cnt_q     <= '0;
              neg_quo_q <= a_neg ^ b_neg;
              neg_rem_q <= a_neg;
            end
          end
        end
        RUN: begin
          if (!flush) begin
            dvd_q <= quo_it;
            rem_q <= rem_it;
            cnt_q <= cnt_q + CNT_W'(1);
            if (cnt_q == LAST_ITER) begin
              quotient_q  <= quo_fix;
              remainder_q <= rem_fix;
              dbz_q       <= 1'b0;
            end
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_alu_div_sequencer.sv
// Directed bench for alu_div_sequencer with a result scoreboard.
module tb_alu_div_sequencer;

  localparam int unsigned W = 32;

  typedef struct packed {
    logic [W-1:0] q;
    logic [W-1:0] r;
    logic         dbz;
  } res_t;

  logic         clk, rst_n, start, flush, sgn_mode;
  logic [W-1:0] dividend, divisor;
  logic         busy, done, div_by_zero;
  logic [W-1:0] quotient, remainder;

  res_t sb[$];
  int   tests = 0;
  int   fails = 0;

  alu_div_sequencer #(.WIDTH(W)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .start      (start),
    .flush      (flush),
`ifdef DIV_SIGNED_EN
    .is_signed  (sgn_mode),
`endif
    .dividend   (dividend),
    .divisor    (divisor),
    .busy       (busy),
    .done       (done),
    .quotient   (quotient),
    .remainder  (remainder),
    .div_by_zero(div_by_zero)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic res_t model(input logic [W-1:0] a, input logic [W-1:0] b, input logic s);
    res_t         res;
    logic [W-1:0] am, bm;
    logic         an, bn;
    if (b == '0) begin
      res.q = '1; res.r = a; res.dbz = 1'b1;
    end else begin
      an = s & a[W-1];
      bn = s & b[W-1];
      am = an ? (~a + 1) : a;
      bm = bn ? (~b + 1) : b;
      res.q = am / bm;
      res.r = am % bm;
      if (an ^ bn) res.q = ~res.q + 1;
      if (an)      res.r = ~res.r + 1;
      res.dbz = 1'b0;
    end
    return res;
  endfunction

  task automatic chk(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Called at negedge: drive a start pulse and optionally record the expected result.
  task automatic issue(input logic [W-1:0] a, input logic [W-1:0] b, input bit push);
    start = 1'b1; dividend = a; divisor = b;
    if (push) sb.push_back(model(a, b, sgn_mode));
    #1;
  endtask

  // Counts negedges to done and busy-high samples; optionally pokes a stray start at poke_at.
  task automatic wait_done(input string tag, input int exp_lat, input int exp_busy,
                           input int poke_at, input logic [W-1:0] pa, input logic [W-1:0] pb);
    int   lat = 0;
    int   bcnt;
    res_t e;
    bcnt = busy ? 1 : 0;
    while (lat < 60) begin
      @(negedge clk);
      start = 1'b0;
      if (lat + 1 == poke_at) begin
        start = 1'b1; dividend = pa; divisor = pb;
      end
      #1;
      lat++;
      if (busy) bcnt++;
      if (done) break;
    end
    chk({tag, " latency"}, W'(lat), W'(exp_lat));
    if (exp_busy >= 0) chk({tag, " busy cycles"}, W'(bcnt), W'(exp_busy));
    if (sb.size() > 0) begin
      e = sb.pop_front();
      chk({tag, " quotient"}, quotient, e.q);
      chk({tag, " remainder"}, remainder, e.r);
      chk({tag, " div_by_zero"}, W'(div_by_zero), W'(e.dbz));
    end else begin
      chk({tag, " scoreboard entry"}, W'(0), W'(1));
    end
  endtask

  task automatic cycles(input int n);
    for (int i = 0; i < n; i++) @(negedge clk);
    #1;
  endtask

  initial begin
    int           dcnt;
    logic [W-1:0] ra, rb;
    rst_n = 1'b0; start = 1'b0; flush = 1'b0; sgn_mode = 1'b0;
    dividend = '0; divisor = '0;

    // Reset state.
    cycles(2);
    chk("reset busy", W'(busy), W'(0));
    chk("reset done", W'(done), W'(0));
    chk("reset quotient", quotient, W'(0));
    chk("reset remainder", remainder, W'(0));
    chk("reset div_by_zero", W'(div_by_zero), W'(0));
    @(negedge clk); rst_n = 1'b1;
    cycles(1);

    // Basic unsigned, divide by zero, extremes.
    @(negedge clk); issue(32'd100, 32'd7, 1'b1);
    wait_done("100/7", 33, 33, 0, '0, '0);
    @(negedge clk); issue(32'd5, 32'd0, 1'b1);
    wait_done("5/0", 1, 1, 0, '0, '0);
    @(negedge clk); issue(32'hFFFF_FFFF, 32'd1, 1'b1);
    wait_done("ffffffff/1", 33, 33, 0, '0, '0);
    @(negedge clk); issue(32'd3, 32'hFFFF_FFFF, 1'b1);
    wait_done("3/ffffffff", 33, 33, 0, '0, '0);

    // Random unsigned operands.
    for (int i = 0; i < 4; i++) begin
      ra = $urandom;
      rb = $urandom_range(1, 65535);
      if (i == 3) rb = $urandom | 32'h8000_0000;
      @(negedge clk); issue(ra, rb, 1'b1);
      wait_done("random", 33, 33, 0, '0, '0);
    end

    // Stray start at iteration 10 is ignored; reissue in the DONE cycle.
    @(negedge clk); issue(32'd1000, 32'd10, 1'b1);
    wait_done("1000/10 stray start", 33, 33, 11, 32'd20, 32'd3);
    issue(32'd20, 32'd3, 1'b1);
    wait_done("20/3 back-to-back", 33, 33, 0, '0, '0);

    // Flush at iteration 15: no done, results held.
    @(negedge clk); issue(32'd50, 32'd5, 1'b0);
    @(negedge clk); start = 1'b0;
    cycles(14);
    flush = 1'b1;
    @(negedge clk); flush = 1'b0; #1;
    chk("flush busy", W'(busy), W'(0));
    dcnt = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk); #1;
      if (done) dcnt++;
    end
    chk("flush done pulses", W'(dcnt), W'(0));
    chk("flush quotient held", quotient, W'(6));
    chk("flush remainder held", remainder, W'(2));

    // Asynchronous reset mid-RUN clears outputs at once.
    @(negedge clk); issue(32'd100, 32'd7, 1'b0);
    @(negedge clk); start = 1'b0;
    cycles(9);
    #2 rst_n = 1'b0;
    #1;
    chk("async reset busy", W'(busy), W'(0));
    chk("async reset done", W'(done), W'(0));
    chk("async reset quotient", quotient, W'(0));
    chk("async reset remainder", remainder, W'(0));
    chk("async reset div_by_zero", W'(div_by_zero), W'(0));
    @(negedge clk); rst_n = 1'b1;
    cycles(1);

`ifdef DIV_SIGNED_EN
    sgn_mode = 1'b1;
    @(negedge clk); issue(32'hFFFF_FFF9, 32'd2, 1'b1);
    wait_done("-7/2", 33, 33, 0, '0, '0);
    chk("-7/2 quotient const", quotient, 32'hFFFF_FFFD);
    chk("-7/2 remainder const", remainder, 32'hFFFF_FFFF);
    @(negedge clk); issue(32'h8000_0000, 32'hFFFF_FFFF, 1'b1);
    wait_done("min/-1", 33, 33, 0, '0, '0);
    chk("min/-1 quotient const", quotient, 32'h8000_0000);
    @(negedge clk); issue(32'd7, 32'd0, 1'b1);
    wait_done("signed 7/0", 1, 1, 0, '0, '0);
    sgn_mode = 1'b0;
`endif

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
